cpu_result_checker: RTL and testbench
=====================================

Name: cpu_result_checker

Overview:
- Cycle-accurate, parametrised self-checking monitor for CPU program benches.
- Replaces the fixed-delay, hard-coded register comparison with a snooped shadow register file and a programmable table of expected values.
- Detects program end by END_PC match, PC stall, or timeout, then checks the table one entry per cycle.
- Reports done, pass or fail, a mismatch count and the first failing entry.
- Sits beside `execution`: it snoops PC and register-file write-port signals and never drives the CPU.

Parameters:
NUM_CHECKS, 4, number of expected-value table entries (1..32)
DATA_WIDTH, 32, register data width
TIMEOUT_CYCLES, 1000, RUN cycles before a timeout is declared
END_PC, 32'h0000_0040, PC value treated as program end
STALL_CYCLES, 3, consecutive cycles of unchanged PC treated as end (jump-to-self)
END_MODE, 2, 0 = END_PC only; 1 = stall only; 2 = either

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins monitoring
pc  input  32  CPU program counter
reg_we  input  1  CPU register-file write enable
reg_waddr  input  5  CPU register-file write address
reg_wdata  input  DATA_WIDTH  CPU register-file write data
exp_we  input  1  expected-table write strobe
exp_idx  input  $clog2(NUM_CHECKS) (min 1)  table entry index
exp_reg  input  5  register number to check
exp_val  input  DATA_WIDTH  expected value
exp_en  input  1  entry valid bit
done  output  1  result valid
pass  output  1  all valid entries matched and no timeout
timeout  output  1  end condition not reached within TIMEOUT_CYCLES
fail_count  output  6  number of mismatching valid entries
first_fail_idx  output  $clog2(NUM_CHECKS) (min 1)  index of the lowest mismatching entry
first_fail_act  output  DATA_WIDTH  shadow value of that entry

Behaviour:
- States: IDLE, RUN, CHECK, DONE.
- Reset (synchronous, highest priority):
  - state IDLE; all outputs 0.
  - Shadow file all 0; all table valid bits 0.
  - Cycle, stall and check counters 0.
- Reset asserted mid-RUN or mid-CHECK aborts immediately; no result is reported.

IDLE:
- exp_we writes table[exp_idx] = {exp_en, exp_reg, exp_val} at the clock edge.
- exp_we in any other state is ignored.
- start -> RUN. On entry: cycle counter 0, stall counter 0, shadow file cleared, done/pass/timeout/fail_count cleared.

RUN:
- Each cycle with reg_we=1 and reg_waddr!=0, shadow[reg_waddr] <= reg_wdata. Writes to $zero are discarded.
- Cycle counter increments each cycle.
- Stall counter increments when pc equals its previous-cycle value, otherwise resets to 0.
- End condition:
  - END_MODE 0: pc==END_PC.
  - END_MODE 1: stall counter reaches STALL_CYCLES-1 while pc is unchanged.
  - END_MODE 2: either condition.
- End -> CHECK. The write snooped in the end cycle is still committed to the shadow file.
- Cycle counter reaching TIMEOUT_CYCLES-1 without an end condition -> CHECK with the timeout flag set.
- If end and timeout occur in the same cycle, end wins and timeout stays 0.
- start in RUN is ignored.

CHECK:
- Check index i runs 0..NUM_CHECKS-1, one entry per cycle; latency is exactly NUM_CHECKS cycles.
- Entries with valid=0 are skipped (no count change).
- On mismatch (shadow[exp_reg] != exp_val) fail_count increments.
- On the first mismatch only, capture first_fail_idx=i and first_fail_act.
- An entry with exp_reg=0 compares against 0.
- After the last index -> DONE.
- Snooped writes are ignored.

DONE:
- done=1; pass = (fail_count==0) && !timeout.
- All result outputs are held until reset or start.
- start in DONE -> RUN (re-run). The table is retained; results are cleared on the entry cycle.
- With no valid table entries and no timeout, pass=1.
- fail_count saturates at 63.

Test Plan:
- Fib program:
  - Stimulus: table {0:$v0=1, 1:$a0=0x3a, 2:$a1=0xa}, END_MODE 1; bench drives the final writes, then holds PC constant for 3 cycles.
  - Required: done=1 exactly NUM_CHECKS cycles after the end cycle; pass=1; fail_count=0.
- Single mismatch:
  - Stimulus: same table, but the last write is $a0=0x39.
  - Required: pass=0, fail_count=1, first_fail_idx=1, first_fail_act=0x39.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=50 and PC incrementing by 4 every cycle.
  - Required: timeout=1 and pass=0 after cycle 50; done asserts NUM_CHECKS cycles later.
- Same-cycle end and write:
  - Stimulus: a write of $a1=0xa in the same cycle pc==END_PC (END_MODE 0).
  - Required: shadow captures it; pass=1.
- Zero register and invalid entries:
  - Stimulus: write $zero=0x55; entry 3 = {$zero, 0, valid}; entry 2 invalid with a wrong value.
  - Required: pass=1, fail_count=0.
- Reset and restart:
  - Stimulus: reset during CHECK.
  - Required: next cycle done=0 and state IDLE, table invalidated.
  - Stimulus: from DONE, start re-runs with the table retained; outputs cleared on the entry cycle.

Source files
------------

// File: rtl/cpu_result_checker.sv
// -----------------------------------------------------------------------------
// cpu_result_checker
//
// Self-checking monitor that sits beside a CPU core. It snoops the program
// counter and the register-file write port into a private shadow register
// file, waits for the program to end, and then compares the shadow file
// against a small programmable table of expected values, one entry per
// cycle. It never drives the CPU.
//
// The program is considered finished when the PC hits END_PC, when the PC
// stays the same for STALL_CYCLES consecutive samples (a jump-to-self), or
// both, depending on END_MODE. If neither happens within TIMEOUT_CYCLES,
// the monitor gives up, sets the timeout flag and checks anyway.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle pulse that begins or restarts monitoring
//   pc                  CPU program counter
//   reg_we/waddr/wdata  snooped CPU register-file write port
//   exp_we/idx/reg/val/en
//                       expected-table write port, accepted only while idle
//   done                result valid, held until reset or start
//   pass                every valid entry matched and no timeout occurred
//   timeout             end of program not seen in time
//   fail_count          number of mismatching valid entries, saturating at 63
//   first_fail_idx/act  lowest mismatching entry and its shadow value
// -----------------------------------------------------------------------------
module cpu_result_checker #(
    parameter int          NUM_CHECKS     = 4,
    parameter int          DATA_WIDTH     = 32,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter logic [31:0] END_PC         = 32'h0000_0040,
    parameter int          STALL_CYCLES   = 3,
    parameter int          END_MODE       = 2,
    localparam int         IW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [31:0]           pc,
    input  logic                  reg_we,
    input  logic [4:0]            reg_waddr,
    input  logic [DATA_WIDTH-1:0] reg_wdata,
    input  logic                  exp_we,
    input  logic [IW-1:0]         exp_idx,
    input  logic [4:0]            exp_reg,
    input  logic [DATA_WIDTH-1:0] exp_val,
    input  logic                  exp_en,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [5:0]            fail_count,
    output logic [IW-1:0]         first_fail_idx,
    output logic [DATA_WIDTH-1:0] first_fail_act
);

    // Wide enough that neither counter can wrap before the timeout fires;
    // the stall counter can never run ahead of the cycle counter.
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cyc_q, cyc_d;
    logic [CW-1:0]         stall_q, stall_d;
    logic [IW-1:0]         chk_idx_q, chk_idx_d;
    logic [31:0]           pc_prev_q, pc_prev_d;

    logic [DATA_WIDTH-1:0] shadow_q [32];
    logic [DATA_WIDTH-1:0] shadow_d [32];

    logic                  tbl_en_q  [NUM_CHECKS];
    logic                  tbl_en_d  [NUM_CHECKS];
    logic [4:0]            tbl_reg_q [NUM_CHECKS];
    logic [4:0]            tbl_reg_d [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] tbl_val_q [NUM_CHECKS];
    logic [DATA_WIDTH-1:0] tbl_val_d [NUM_CHECKS];

    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  timeout_q, timeout_d;
    logic [5:0]            fail_count_q, fail_count_d;
    logic [IW-1:0]         ff_idx_q, ff_idx_d;
    logic [DATA_WIDTH-1:0] ff_act_q, ff_act_d;

    logic                  pc_same_s;
    logic [CW-1:0]         stall_inc_s;
    logic                  end_pc_hit_s;
    logic                  end_stall_hit_s;
    logic                  end_hit_s;
    logic                  begin_run_s;
    logic [4:0]            chk_reg_s;
    logic [DATA_WIDTH-1:0] chk_act_s;
    logic                  mismatch_s;

    // Next-state, table, shadow-file and result computation.
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stall_d      = stall_q;
        chk_idx_d    = chk_idx_q;
        pc_prev_d    = pc;
        shadow_d     = shadow_q;
        tbl_en_d     = tbl_en_q;
        tbl_reg_d    = tbl_reg_q;
        tbl_val_d    = tbl_val_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_count_d = fail_count_q;
        ff_idx_d     = ff_idx_q;
        ff_act_d     = ff_act_q;

        // The counter counts repeat samples, so STALL_CYCLES equal samples
        // correspond to an incremented count of STALL_CYCLES-1.
        pc_same_s       = (pc == pc_prev_q);
        stall_inc_s     = stall_q + {{(CW-1){1'b0}}, 1'b1};
        end_pc_hit_s    = (pc == END_PC);
        end_stall_hit_s = pc_same_s && (stall_inc_s >= CW'(STALL_CYCLES - 1));

        case (END_MODE)
            32'sd0:  end_hit_s = end_pc_hit_s;
            32'sd1:  end_hit_s = end_stall_hit_s;
            default: end_hit_s = end_pc_hit_s || end_stall_hit_s;
        endcase

        // $zero reads as zero regardless of what the shadow holds.
        chk_reg_s  = tbl_reg_q[chk_idx_q];
        chk_act_s  = (chk_reg_s == 5'd0) ? '0 : shadow_q[chk_reg_s];
        mismatch_s = tbl_en_q[chk_idx_q] && (chk_act_s != tbl_val_q[chk_idx_q]);

        begin_run_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
                if (exp_we && (int'(exp_idx) < NUM_CHECKS)) begin
                    tbl_en_d[exp_idx]  = exp_en;
                    tbl_reg_d[exp_idx] = exp_reg;
                    tbl_val_d[exp_idx] = exp_val;
                end else begin
                    tbl_en_d = tbl_en_q;
                end
            end

            S_RUN: begin
                if (reg_we && (reg_waddr != 5'd0)) begin
                    shadow_d[reg_waddr] = reg_wdata;
                end else begin
                    shadow_d = shadow_q;
                end
                cyc_d   = cyc_q + {{(CW-1){1'b0}}, 1'b1};
                stall_d = pc_same_s ? stall_inc_s : '0;
                // End takes priority over a timeout in the same cycle.
                if (end_hit_s) begin
                    state_d   = S_CHECK;
                    chk_idx_d = '0;
                end else if (cyc_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = S_CHECK;
                    chk_idx_d = '0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end

            S_CHECK: begin
                if (mismatch_s) begin
                    fail_count_d = (fail_count_q == 6'd63) ? 6'd63 : fail_count_q + 6'd1;
                    if (fail_count_q == 6'd0) begin
                        ff_idx_d = chk_idx_q;
                        ff_act_d = chk_act_s;
                    end else begin
                        ff_idx_d = ff_idx_q;
                    end
                end else begin
                    fail_count_d = fail_count_q;
                end
                if (chk_idx_q == IW'(NUM_CHECKS - 1)) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == 6'd0) && !timeout_q;
                end else begin
                    chk_idx_d = chk_idx_q + {{(IW-1){1'b0}}, 1'b1};
                end
            end

            S_DONE: begin
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Entering RUN (first run or re-run) starts from a clean slate but
        // keeps the programmed table.
        if (begin_run_s) begin
            state_d      = S_RUN;
            cyc_d        = '0;
            stall_d      = '0;
            chk_idx_d    = '0;
            done_d       = 1'b0;
            pass_d       = 1'b0;
            timeout_d    = 1'b0;
            fail_count_d = 6'd0;
            ff_idx_d     = '0;
            ff_act_d     = '0;
            for (int i = 0; i < 32; i++) begin
                shadow_d[i] = '0;
            end
        end else begin
            pc_prev_d = pc;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cyc_q        <= '0;
            stall_q      <= '0;
            chk_idx_q    <= '0;
            pc_prev_q    <= '0;
            shadow_q     <= '{default: '0};
            tbl_en_q     <= '{default: 1'b0};
            tbl_reg_q    <= '{default: 5'd0};
            tbl_val_q    <= '{default: '0};
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_count_q <= 6'd0;
            ff_idx_q     <= '0;
            ff_act_q     <= '0;
        end else begin
            state_q      <= state_d;
            cyc_q        <= cyc_d;
            stall_q      <= stall_d;
            chk_idx_q    <= chk_idx_d;
            pc_prev_q    <= pc_prev_d;
            shadow_q     <= shadow_d;
            tbl_en_q     <= tbl_en_d;
            tbl_reg_q    <= tbl_reg_d;
            tbl_val_q    <= tbl_val_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_count_q <= fail_count_d;
            ff_idx_q     <= ff_idx_d;
            ff_act_q     <= ff_act_d;
        end
    end

    assign done           = done_q;
    assign pass           = pass_q;
    assign timeout        = timeout_q;
    assign fail_count     = fail_count_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_act = ff_act_q;

endmodule

// File: tb/tb_cpu_result_checker.sv
// -----------------------------------------------------------------------------
// tb_cpu_result_checker
//
// Directed and randomized program runs against cpu_result_checker. A
// reference model keeps a plain array for the register file, a list of
// sampled PC values and a copy of the expected table; from these it decides
// when the program ends and what the reported result must be.
// -----------------------------------------------------------------------------
module tb_cpu_result_checker;

    localparam int          N     = 4;
    localparam int          TMO   = 50;
    localparam logic [31:0] ENDPC = 32'h0000_0040;
    localparam int          STALL = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc;
    logic        reg_we;
    logic [4:0]  reg_waddr;
    logic [31:0] reg_wdata;
    logic        exp_we;
    logic [1:0]  exp_idx;
    logic [4:0]  exp_reg;
    logic [31:0] exp_val;
    logic        exp_en;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [5:0]  fail_count;
    logic [1:0]  first_fail_idx;
    logic [31:0] first_fail_act;

    cpu_result_checker #(
        .NUM_CHECKS     (N),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (TMO),
        .END_PC         (ENDPC),
        .STALL_CYCLES   (STALL),
        .END_MODE       (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .pc             (pc),
        .reg_we         (reg_we),
        .reg_waddr      (reg_waddr),
        .reg_wdata      (reg_wdata),
        .exp_we         (exp_we),
        .exp_idx        (exp_idx),
        .exp_reg        (exp_reg),
        .exp_val        (exp_val),
        .exp_en         (exp_en),
        .done           (done),
        .pass           (pass),
        .timeout        (timeout),
        .fail_count     (fail_count),
        .first_fail_idx (first_fail_idx),
        .first_fail_act (first_fail_act)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model state.
    logic [31:0] m_regs [32];
    bit          m_en   [N];
    logic [4:0]  m_reg  [N];
    logic [31:0] m_val  [N];
    logic [31:0] pc_hist [$];
    int          m_cycles;
    bit          m_end;
    bit          m_tmo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        start  = 1'b0;
        reg_we = 1'b0;
        exp_we = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < N; i++) m_en[i] = 1'b0;
    endtask

    task automatic prog(input int idx, input int r, input logic [31:0] v, input bit en);
        exp_we  = 1'b1;
        exp_idx = 2'(idx);
        exp_reg = 5'(r);
        exp_val = v;
        exp_en  = en;
        tick();
        exp_we   = 1'b0;
        m_en[idx]  = en;
        m_reg[idx] = 5'(r);
        m_val[idx] = v;
    endtask

    task automatic do_start(input logic [31:0] pc0);
        start  = 1'b1;
        pc     = pc0;
        reg_we = 1'b0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        pc_hist.delete();
        pc_hist.push_back(pc0);
        m_cycles = 0;
        m_end    = 1'b0;
        m_tmo    = 1'b0;
    endtask

    // One CPU cycle while the monitor is running; the model decides whether
    // this cycle ends the program or exhausts the cycle budget.
    task automatic run_cycle(input logic [31:0] p, input bit we, input int a, input logic [31:0] d);
        bit stalled;
        pc        = p;
        reg_we    = we;
        reg_waddr = 5'(a);
        reg_wdata = d;
        m_cycles++;
        pc_hist.push_back(p);
        if (we && a != 0) m_regs[a] = d;
        stalled = (pc_hist.size() >= STALL);
        if (stalled) begin
            for (int k = 1; k < STALL; k++) begin
                if (pc_hist[pc_hist.size() - 1 - k] != p) stalled = 1'b0;
            end
        end
        m_end = stalled || (p == ENDPC);
        m_tmo = !m_end && (m_cycles == TMO);
        tick();
        reg_we = 1'b0;
    endtask

    function automatic bit finished();
        return m_end || m_tmo;
    endfunction

    // Called right after the end cycle: follows the check phase and compares
    // the reported result with what the table and model registers imply.
    task automatic check_result(input string tag);
        int          fails;
        int          ffi;
        logic [31:0] ffa;
        logic [31:0] act;
        fails = 0;
        ffi   = 0;
        ffa   = 32'd0;
        for (int i = 0; i < N; i++) begin
            if (m_en[i]) begin
                act = (m_reg[i] == 5'd0) ? 32'd0 : m_regs[m_reg[i]];
                if (act != m_val[i]) begin
                    if (fails == 0) begin
                        ffi = i;
                        ffa = act;
                    end
                    fails++;
                end
            end
        end
        check({tag, ".done_at_end"}, done, 1'b0);
        check({tag, ".timeout"}, timeout, m_tmo);
        repeat (N - 1) tick();
        check({tag, ".done_early"}, done, 1'b0);
        tick();
        check({tag, ".done"}, done, 1'b1);
        check({tag, ".pass"}, pass, (fails == 0) && !m_tmo);
        check({tag, ".fail_count"}, fail_count, (fails > 63) ? 63 : fails);
        check({tag, ".first_fail_idx"}, first_fail_idx, (fails > 0) ? ffi : 0);
        check({tag, ".first_fail_act"}, first_fail_act, (fails > 0) ? ffa : 32'd0);
    endtask

    // Fib-like run: random writes, the final results, then a jump-to-self.
    task automatic fib_run(input logic [31:0] pc0, input logic [31:0] a0_val, input bit write_v0);
        logic [31:0] p;
        do_start(pc0);
        p = pc0 + 32'd4;
        for (int i = 0; i < 8; i++) begin
            run_cycle(p, 1'b1, int'($urandom_range(1, 31)), $urandom);
            p += 32'd4;
        end
        if (write_v0) begin
            run_cycle(p, 1'b1, 2, 32'd1);
            p += 32'd4;
        end
        run_cycle(p, 1'b1, 4, a0_val);
        p += 32'd4;
        run_cycle(p, 1'b1, 5, 32'h0000_000a);
        p += 32'd4;
        for (int i = 0; i < 6 && !finished(); i++) run_cycle(p, 1'b0, 0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] p;
        int          r;

        pc = 32'd0; reg_waddr = 5'd0; reg_wdata = 32'd0;
        exp_idx = 2'd0; exp_reg = 5'd0; exp_val = 32'd0; exp_en = 1'b0;
        do_reset();

        // Reset state.
        check("reset.done", done, 1'b0);
        check("reset.pass", pass, 1'b0);
        check("reset.timeout", timeout, 1'b0);
        check("reset.fail_count", fail_count, 6'd0);
        check("reset.first_fail_idx", first_fail_idx, 2'd0);
        check("reset.first_fail_act", first_fail_act, 32'd0);

        // Fib program ending on a PC stall.
        prog(0, 2, 32'd1, 1'b1);
        prog(1, 4, 32'h3a, 1'b1);
        prog(2, 5, 32'h0a, 1'b1);
        fib_run(32'h0000_0400, 32'h3a, 1'b1);
        check_result("fib");

        // Single mismatch on $a0.
        do_reset();
        prog(0, 2, 32'd1, 1'b1);
        prog(1, 4, 32'h3a, 1'b1);
        prog(2, 5, 32'h0a, 1'b1);
        fib_run(32'h0000_0400, 32'h39, 1'b1);
        check_result("mismatch");

        // Re-run from DONE: results clear on entry, table kept, shadow cleared
        // (so the never-written $v0 reads back as 0).
        fib_run(32'h0000_0800, 32'h3a, 1'b0);
        check_result("rerun");
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_entry.done", done, 1'b0);
        check("rerun_entry.pass", pass, 1'b0);
        check("rerun_entry.fail_count", fail_count, 6'd0);
        check("rerun_entry.timeout", timeout, 1'b0);

        // Timeout with a steadily advancing PC; a table write during RUN is ignored.
        do_reset();
        for (int i = 0; i < N; i++) prog(i, int'($urandom_range(0, 31)), $urandom, 1'b1);
        do_start(32'h0000_0100);
        p = 32'h0000_0104;
        exp_we = 1'b1; exp_idx = 2'd0; exp_reg = 5'd0; exp_val = 32'd0; exp_en = 1'b0;
        for (int i = 0; i < 2 * TMO && !finished(); i++) begin
            run_cycle(p, 1'b1, int'($urandom_range(0, 31)), $urandom);
            exp_we = 1'b0;
            if (m_cycles == TMO - 1) check("timeout.not_yet", timeout, 1'b0);
            p += 32'd4;
        end
        check_result("timeout");

        // End on END_PC with a write committed in that same cycle.
        do_reset();
        prog(0, 5, 32'h0a, 1'b1);
        do_start(32'h0000_0010);
        for (p = 32'h14; p < ENDPC; p += 32'd4) run_cycle(p, 1'b1, 5, 32'h77);
        run_cycle(ENDPC, 1'b1, 5, 32'h0a);
        check_result("same_cycle");

        // $zero entry, an invalid entry holding a wrong value, write to $zero.
        do_reset();
        prog(0, 2, 32'h11, 1'b1);
        prog(2, 6, 32'hdead, 1'b0);
        prog(3, 0, 32'd0, 1'b1);
        do_start(32'h0000_0300);
        run_cycle(32'h304, 1'b1, 2, 32'h11);
        run_cycle(32'h308, 1'b1, 0, 32'h55);
        run_cycle(32'h30c, 1'b1, 6, 32'h1);
        run_cycle(ENDPC, 1'b0, 0, 32'd0);
        check_result("zero_invalid");

        // Reset during CHECK aborts; the table comes back invalid.
        do_reset();
        prog(0, 2, 32'd5, 1'b1);
        do_start(32'h0000_0500);
        run_cycle(32'h504, 1'b1, 2, 32'd9);
        run_cycle(ENDPC, 1'b0, 0, 32'd0);
        tick();
        do_reset();
        check("abort.done", done, 1'b0);
        check("abort.fail_count", fail_count, 6'd0);
        repeat (N + 2) tick();
        check("abort.stays_idle", done, 1'b0);
        do_start(32'h0000_0600);
        run_cycle(32'h604, 1'b1, 2, 32'd9);
        run_cycle(ENDPC, 1'b0, 0, 32'd0);
        check_result("abort_rerun");

        // Randomized programs: random table, random writes, PC that advances,
        // sometimes holds and sometimes jumps to END_PC.
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int i = 0; i < N; i++)
                prog(i, int'($urandom_range(0, 7)), 32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
            do_start(32'h0000_0200);
            p = 32'h0000_0204;
            for (int c = 0; c < 2 * TMO && !finished(); c++) begin
                r = int'($urandom_range(0, 19));
                if (r == 0) p = ENDPC;
                else if (r >= 6) p += 32'd4;
                run_cycle(p, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                          32'($urandom_range(0, 3)));
            end
            check_result($sformatf("random%0d", it));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
